// File: rtl/reg_file_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port register file.
// Optional macro RF_ARB_ADDR_CHECK_EN turns out-of-range addresses into error responses.
module reg_file_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_FILE_DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              req,
  input  logic [1:0]              we,
  input  logic [2*ADDR_WIDTH-1:0] addr,
  input  logic [2*DATA_WIDTH-1:0] wdata,
  output logic [1:0]              done,
  output logic [1:0]              err,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    rf_rd_en,
  output logic                    rf_wr_en,
  output logic [ADDR_WIDTH-1:0]   rf_address,
  output logic [DATA_WIDTH-1:0]   rf_wr_data,
  input  logic [DATA_WIDTH-1:0]   rf_rd_data,
  output logic [1:0]              state_dbg
);

  // Handshake: a requester holds req[i] (with we/addr/wdata stable) until it sees
  // done[i] for one cycle, then drops req[i] the next cycle; a held req is a new request.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic                    last_grant;
  logic                    grant_id;
  logic                    cmd_id;
  logic                    cmd_we;
  logic [ADDR_WIDTH-1:0]   cmd_addr;
  logic [DATA_WIDTH-1:0]   cmd_wdata;
  logic                    addr_ok;
  logic [ADDR_WIDTH-1:0]   eff_addr;

`ifdef RF_ARB_ADDR_CHECK_EN
  logic err_q;

  assign addr_ok  = ({1'b0, cmd_addr} < (ADDR_WIDTH+1)'(REG_FILE_DEPTH));
  assign eff_addr = cmd_addr;
  assign err      = done & {2{err_q}};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (state == ACCESS) begin
      err_q <= !addr_ok;
    end
  end
`else
  localparam int IDX_W = (REG_FILE_DEPTH > 1) ? $clog2(REG_FILE_DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ADDR_WIDTH'((64'd1 << IDX_W) - 64'd1);

  // Without checking, out-of-range addresses wrap onto the implemented words.
  assign addr_ok  = 1'b1;
  assign eff_addr = cmd_addr & ADDR_MASK;
  assign err      = 2'b00;
`endif

  assign state_dbg = state;

  // On a tie the requester that did not win last time is preferred.
  always_comb begin
    grant_id = 1'b0;
    case (req)
      2'b01:   grant_id = 1'b0;
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = ~last_grant;
      default: grant_id = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cmd_id     <= 1'b0;
      cmd_we     <= 1'b0;
      cmd_addr   <= '0;
      cmd_wdata  <= '0;
      rdata      <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req != 2'b00) begin
        last_grant <= grant_id;
        cmd_id     <= grant_id;
        cmd_we     <= we[grant_id];
        cmd_addr   <= grant_id ? addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : addr[ADDR_WIDTH-1:0];
        cmd_wdata  <= grant_id ? wdata[2*DATA_WIDTH-1:DATA_WIDTH] : wdata[DATA_WIDTH-1:0];
      end
      if (state == ACCESS) begin
        rdata <= (cmd_we || !addr_ok) ? '0 : rf_rd_data;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    rf_rd_en   = 1'b0;
    rf_wr_en   = 1'b0;
    rf_address = '0;
    rf_wr_data = '0;
    done       = 2'b00;
    case (state)
      IDLE: begin
        if (req != 2'b00) state_nxt = ACCESS;
      end
      ACCESS: begin
        state_nxt  = RESP;
        rf_wr_en   = cmd_we && addr_ok;
        rf_rd_en   = !cmd_we && addr_ok;
        rf_address = eff_addr;
        rf_wr_data = cmd_wdata;
      end
      RESP: begin
        state_nxt    = IDLE;
        done[cmd_id] = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/reg_file_arbiter.md
REG_FILE_ARBITER -- requirements
Module: reg_file_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, data width of the requester ports and the register file port.
REQ-002 Parameter ADDR_WIDTH, default 32, address width of the requester ports and the register file port.
REQ-003 Parameter REG_FILE_DEPTH, default 16, number of words in the downstream register file.
REQ-004 Port clk, input, 1, clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1, reset: asynchronous, active-low.
REQ-006 Port req, input, 2, per-requester access request; bit i belongs to requester i.
REQ-007 Port we, input, 2, per-requester write select (1 = write, 0 = read); valid while req[i]=1.
REQ-008 Port addr, input, 2*ADDR_WIDTH, word address; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-009 Port wdata, input, 2*DATA_WIDTH, write data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 Port done, output, 2, one-cycle completion pulse for requester i.
REQ-011 Port err, output, 2, error flag for requester i; valid only while done[i]=1.
REQ-012 Port rdata, output, DATA_WIDTH, read data shared by both requesters; valid while done=1 for a read.
REQ-013 Ports rf_rd_en and rf_wr_en, output, 1 each, register file read and write strobes.
REQ-014 Port rf_address, output, ADDR_WIDTH, register file address.
REQ-015 Port rf_wr_data, output, DATA_WIDTH, register file write data.
REQ-016 Port rf_rd_data, input, DATA_WIDTH, combinational read data returned by the register file.

Function
REQ-017 The arbiter SHALL implement the three-state FSM IDLE -> ACCESS -> RESP -> IDLE.
REQ-018 IDLE: if any req bit is 1, the arbiter SHALL select a winner, latch that winner's id, we, addr and wdata, and go to ACCESS; otherwise it SHALL stay in IDLE.
REQ-019 The arbiter SHALL sample req only in IDLE; req changes during ACCESS or RESP SHALL be ignored.
REQ-020 Arbitration SHALL be round-robin: with a single requester, that requester wins; with both requesting, the requester not granted last wins.
REQ-021 The last-grant pointer SHALL update only when a grant is made in IDLE.
REQ-022 ACCESS: for exactly one cycle the arbiter SHALL drive rf_address and rf_wr_data from the latched values, with rf_wr_en=we and rf_rd_en=!we; rf_rd_en and rf_wr_en SHALL never both be 1.
REQ-023 ACCESS: on a read, rdata SHALL capture rf_rd_data at the end of the cycle; on a write, rdata SHALL be set to 0.
REQ-024 RESP: done[winner]=1 for exactly one cycle, err[winner] valid, then the FSM SHALL return to IDLE.
REQ-025 In every state other than ACCESS, rf_rd_en and rf_wr_en SHALL be 0 and rf_address and rf_wr_data SHALL be 0.
REQ-026 Latency: req sampled high in IDLE at edge N gives ACCESS in cycle N+1 and done in cycle N+2; the minimum spacing between grants is 3 cycles.
REQ-027 A requester SHALL drop req in the cycle after it sees done, or the arbiter treats the held req as a new request.
REQ-028 done and err for the losing requester SHALL remain 0.

Reset
REQ-029 While rst=0, the arbiter SHALL force: state=IDLE, done=0, err=0, rdata=0, all rf_* outputs=0, latched command=0.
REQ-030 While rst=0, the last-grant pointer SHALL be set to requester 1, so requester 0 wins the first tie.
REQ-031 Reset asserted during ACCESS or RESP SHALL abort the transaction with no done pulse; a write issued in ACCESS before the reset edge is not undone.

Configuration
REQ-032 Macro RF_ARB_ADDR_CHECK_EN defined: an address >= REG_FILE_DEPTH SHALL suppress rf_rd_en and rf_wr_en in ACCESS, set rdata=0, and set err[winner]=1 with done in RESP.
REQ-033 Macro RF_ARB_ADDR_CHECK_EN undefined: err SHALL be tied to 0, and every access SHALL be issued with rf_address taken as the latched address masked to its low $clog2(REG_FILE_DEPTH) bits.

Verification
REQ-034 Single write then read: req=01, we=1, addr0=3, wdata0=0xA5A5_0001, followed by a read of addr 3 -> rf_wr_en pulses in cycle N+1, done=01 in cycle N+2, and the read returns rdata=0xA5A5_0001 with err=0.
REQ-035 Simultaneous requests right after reset: req=11 -> requester 0 served first; requester 1 served next (done=01 then done=10, 3 cycles apart).
REQ-036 Fairness: both requesters hold req continuously, dropping and reasserting it after each done -> grants alternate 0,1,0,1 over 8 transactions.
REQ-037 Address 16 with RF_ARB_ADDR_CHECK_EN defined -> no rf strobe, done with err=1, rdata=0; with the macro undefined -> address 0 accessed, err=0.
REQ-038 Reset pulse during ACCESS -> no done pulse, all outputs 0, next req=10 is granted to requester 1 with normal latency.
